// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler
//   One shared "101" Moore detector serving N_CH serial channels. Each channel
//   keeps its own 2-bit detection context and a saturating match counter. A
//   round-robin arbiter grants at most one channel per cycle. The granted
//   channel's bit advances that channel's context.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   en           global enable; no grants while low
//   ch_valid     per-channel bit-available flags
//   ch_bit       per-channel serial data bits
//   ch_ready     one-hot (or zero) grant, combinational
//   ch_clr       per-channel context/counter clear requests
//   match_valid  registered pulse: a "101" completed on match_ch
//   match_ch     channel index of the reported match (holds otherwise)
//   cnt_sel      selects the counter shown on match_cnt
//   match_cnt    combinational readout of counter[cnt_sel]
module seq_detect_scheduler #(
  parameter  int unsigned N_CH  = 4,
  parameter  int unsigned CNT_W = 8,
  localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_CH-1:0]  ch_valid,
  input  logic [N_CH-1:0]  ch_bit,
  output logic [N_CH-1:0]  ch_ready,
  input  logic [N_CH-1:0]  ch_clr,
  output logic             match_valid,
  output logic [SEL_W-1:0] match_ch,
  input  logic [SEL_W-1:0] cnt_sel,
  output logic [CNT_W-1:0] match_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT1  = 2'd1,
    GOT10 = 2'd2,
    MATCH = 2'd3
  } ctx_t;

  ctx_t             r_ctx [N_CH];
  logic [CNT_W-1:0] r_cnt [N_CH];
  logic [SEL_W-1:0] r_rr_ptr;
  logic             r_match_valid;
  logic [SEL_W-1:0] r_match_ch;

  logic [N_CH-1:0]  w_elig;
  logic [N_CH-1:0]  w_ready;
  logic             w_grant_vld;
  logic [SEL_W-1:0] w_grant_idx;
  ctx_t             w_next_ctx;

  // Overlapping detection: MATCH re-enters GOT1/GOT10 so the trailing '1'
  // of one match can start the next.
  function automatic ctx_t f_next_ctx(input ctx_t c, input logic b);
    ctx_t n;
    n = IDLE;
    case (c)
      IDLE:    n = b ? GOT1  : IDLE;
      GOT1:    n = b ? GOT1  : GOT10;
      GOT10:   n = b ? MATCH : IDLE;
      MATCH:   n = b ? GOT1  : GOT10;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  // A channel being cleared is never eligible, so clear and consume cannot
  // both land on the same channel. Reset also blocks every grant.
  always_comb begin
    logic [SEL_W-1:0] v_idx;
    w_elig      = ch_valid & ~ch_clr & {N_CH{en & ~rst}};
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    v_idx       = '0;
    // Scan from rr_ptr upward; N_CH is a power of two so the index wraps.
    for (int unsigned k = 0; k < N_CH; k++) begin
      v_idx = r_rr_ptr + SEL_W'(k);
      if (!w_grant_vld && w_elig[v_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = v_idx;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_grant_vld) w_ready[w_grant_idx] = 1'b1;
  end

  always_comb begin
    w_next_ctx = f_next_ctx(r_ctx[w_grant_idx], ch_bit[w_grant_idx]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        r_ctx[i] <= IDLE;
        r_cnt[i] <= '0;
      end
      r_rr_ptr      <= '0;
      r_match_valid <= 1'b0;
      r_match_ch    <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (ch_clr[i]) begin
          r_ctx[i] <= IDLE;
          r_cnt[i] <= '0;
        end
      end
      r_match_valid <= 1'b0;
      if (w_grant_vld) begin
        r_ctx[w_grant_idx] <= w_next_ctx;
        r_rr_ptr           <= w_grant_idx + SEL_W'(1);
        if (w_next_ctx == MATCH) begin
          r_match_valid <= 1'b1;
          r_match_ch    <= w_grant_idx;
          if (r_cnt[w_grant_idx] != '1)
            r_cnt[w_grant_idx] <= r_cnt[w_grant_idx] + CNT_W'(1);
        end
      end
    end
  end

  assign ch_ready    = w_ready;
  assign match_valid = r_match_valid;
  assign match_ch    = r_match_ch;
  assign match_cnt   = r_cnt[cnt_sel];

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// tb_seq_detect_scheduler
//   Directed bench for seq_detect_scheduler. A table of per-cycle vectors
//   covers single-channel detection, round-robin order, enable freeze and
//   multi-channel clears. Hand-written sequences cover clear-versus-bit,
//   enable gaps, reset mid-sequence, counter saturation (second instance
//   with CNT_W=2) and reset during traffic.
module tb_seq_detect_scheduler;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] ch_valid;
  logic [3:0] ch_bit;
  logic [3:0] ch_clr;
  logic [1:0] cnt_sel;

  logic [3:0] ch_ready;
  logic       match_valid;
  logic [1:0] match_ch;
  logic [7:0] match_cnt;

  logic [3:0] ch_ready2;
  logic       match_valid2;
  logic [1:0] match_ch2;
  logic [1:0] match_cnt2;

  int total;
  int bad;

  seq_detect_scheduler #(.N_CH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_valid(ch_valid), .ch_bit(ch_bit),
    .ch_ready(ch_ready), .ch_clr(ch_clr), .match_valid(match_valid),
    .match_ch(match_ch), .cnt_sel(cnt_sel), .match_cnt(match_cnt)
  );

  seq_detect_scheduler #(.N_CH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .ch_valid(ch_valid), .ch_bit(ch_bit),
    .ch_ready(ch_ready2), .ch_clr(ch_clr), .match_valid(match_valid2),
    .match_ch(match_ch2), .cnt_sel(cnt_sel), .match_cnt(match_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       e;
    logic [3:0] v;
    logic [3:0] b;
    logic [3:0] c;
    logic [1:0] sel;
    logic [3:0] exp_rdy;
    logic       exp_mv;
    logic [1:0] exp_mch;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic e, input logic [3:0] v,
                              input logic [3:0] b, input logic [3:0] c,
                              input logic [1:0] sel, input logic [3:0] rdy,
                              input logic mv, input logic [1:0] mch,
                              input logic [7:0] cnt);
    vec_t t;
    t.r = r; t.e = e; t.v = v; t.b = b; t.c = c; t.sel = sel;
    t.exp_rdy = rdy; t.exp_mv = mv; t.exp_mch = mch; t.exp_cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational grant, then advance
  // past the next rising edge so registered outputs can be checked.
  task automatic step(input logic r, input logic e, input logic [3:0] v,
                      input logic [3:0] b, input logic [3:0] c,
                      input logic [1:0] sel, input logic [3:0] exp_rdy,
                      input string nm);
    rst = r; en = e; ch_valid = v; ch_bit = b; ch_clr = c; cnt_sel = sel;
    #1;
    chk({nm, "_ready"}, 32'(ch_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b0000, "rst");
  endtask

  initial begin
    int p1;
    int p2;
    logic [8:0] pat;
    logic [3:0] bb;
    total = 0;
    bad   = 0;
    rst = 1'b1; en = 1'b0; ch_valid = '0; ch_bit = '0; ch_clr = '0; cnt_sel = '0;

    // Table: single channel, reset with traffic, round robin, freeze, clears.
    tbl.push_back(mk(0, 1, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 1));
    tbl.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 2));
    tbl.push_back(mk(1, 1, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0000, 0, 0, 0));
    for (int c = 0; c < 12; c++) begin
      bb = (c < 4) ? 4'b1111 : (c < 8) ? 4'b0000 : 4'b1111;
      tbl.push_back(mk(0, 1, 4'b1111, bb, 4'b0000, 2'(c % 4), 4'(1 << (c % 4)),
                       (c >= 8), (c >= 8) ? 2'(c % 4) : 2'd0, (c >= 8) ? 8'd1 : 8'd0));
    end
    tbl.push_back(mk(0, 0, 4'b1111, 4'b1111, 4'b0000, 3, 4'b0000, 0, 3, 1));
    tbl.push_back(mk(0, 1, 4'b1111, 4'b0000, 4'b0101, 0, 4'b0010, 0, 3, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 2, 4'b0000, 0, 3, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 3, 1));

    @(posedge clk);
    #1;
    do_reset();
    chk("reset_mv", 32'(match_valid), 0);
    chk("reset_mch", 32'(match_ch), 0);
    chk("reset_cnt", 32'(match_cnt), 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].b, tbl[i].c, tbl[i].sel,
           tbl[i].exp_rdy, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_mv", i), 32'(match_valid), 32'(tbl[i].exp_mv));
      chk($sformatf("vec%0d_mch", i), 32'(match_ch), 32'(tbl[i].exp_mch));
      chk($sformatf("vec%0d_cnt", i), 32'(match_cnt), 32'(tbl[i].exp_cnt));
    end

    // Clear on channel 2 while it offers a bit: excluded, context back to IDLE.
    do_reset();
    step(0, 1, 4'b0100, 4'b0100, 4'b0000, 2, 4'b0100, "clr_b1");
    step(0, 1, 4'b0100, 4'b0000, 4'b0000, 2, 4'b0100, "clr_b0");
    step(0, 1, 4'b0100, 4'b0100, 4'b0100, 2, 4'b0000, "clr_req");
    chk("clr_req_mv", 32'(match_valid), 0);
    step(0, 1, 4'b0100, 4'b0100, 4'b0000, 2, 4'b0100, "clr_after");
    chk("clr_after_mv", 32'(match_valid), 0);
    chk("clr_after_cnt", 32'(match_cnt), 0);

    // Enable low for five cycles between "10" and "1" on channel 3.
    do_reset();
    step(0, 1, 4'b1000, 4'b1000, 4'b0000, 3, 4'b1000, "en_b1");
    step(0, 1, 4'b1000, 4'b0000, 4'b0000, 3, 4'b1000, "en_b0");
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 4'b1000, 4'b1000, 4'b0000, 3, 4'b0000, $sformatf("en_off%0d", k));
      chk($sformatf("en_off%0d_mv", k), 32'(match_valid), 0);
    end
    step(0, 1, 4'b1000, 4'b1000, 4'b0000, 3, 4'b1000, "en_resume");
    chk("en_resume_mv", 32'(match_valid), 1);
    chk("en_resume_mch", 32'(match_ch), 3);
    chk("en_resume_cnt", 32'(match_cnt), 1);

    // "10", reset, "1" must not complete a match.
    do_reset();
    step(0, 1, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, "rmid_b1");
    step(0, 1, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0001, "rmid_b0");
    step(1, 1, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0000, "rmid_rst");
    step(0, 1, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, "rmid_b1b");
    chk("rmid_mv", 32'(match_valid), 0);

    // Saturation: 1,0,1,0,1,0,1,0,1 on channel 1 gives four matches.
    do_reset();
    pat = 9'b101010101;
    p1 = 0;
    p2 = 0;
    for (int k = 0; k < 9; k++) begin
      step(0, 1, 4'b0010, pat[k] ? 4'b0010 : 4'b0000, 4'b0000, 1, 4'b0010,
           $sformatf("sat%0d", k));
      if (match_valid)  p1++;
      if (match_valid2) p2++;
    end
    chk("sat_pulses_w8", 32'(p1), 4);
    chk("sat_pulses_w2", 32'(p2), 4);
    chk("sat_cnt_w8", 32'(match_cnt), 4);
    chk("sat_cnt_w2", 32'(match_cnt2), 3);
    chk("sat_mch_w2", 32'(match_ch2), 1);

    // Reset in the middle of all-channel traffic.
    do_reset();
    for (int c = 0; c < 13; c++) begin
      bb = (c >= 4 && c < 8) ? 4'b0000 : 4'b1111;
      step(0, 1, 4'b1111, bb, 4'b0000, 0, 4'(1 << (c % 4)), $sformatf("trf%0d", c));
    end
    chk("trf_cnt0", 32'(match_cnt), 1);
    step(1, 1, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0000, "trf_rst");
    chk("trf_rst_mv", 32'(match_valid), 0);
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #1;
      chk($sformatf("trf_rst_cnt%0d", s), 32'(match_cnt), 0);
    end
    step(0, 1, 4'b1001, 4'b0000, 4'b0000, 0, 4'b0001, "trf_first");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_scheduler.md
SEQ_DETECT_SCHEDULER -- requirements
Module: seq_detect_scheduler

Interface
REQ-001 Parameter N_CH, default 4, number of serial input channels sharing one "101" detector engine (power of two, >=2).
REQ-002 Parameter CNT_W, default 8, width of each per-channel match counter.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  global enable; when 0, no channel is granted.
REQ-006 ch_valid  input  N_CH  per-channel bit-available flag.
REQ-007 ch_bit  input  N_CH  per-channel serial data bit, meaningful when ch_valid set.
REQ-008 ch_ready  output  N_CH  one-hot (or zero) grant; bit consumed when ch_valid[i] & ch_ready[i].
REQ-009 ch_clr  input  N_CH  per-channel context/counter clear request.
REQ-010 match_valid  output  1  registered pulse: a "101" completed on match_ch.
REQ-011 match_ch  output  log2(N_CH)  channel index of the reported match.
REQ-012 cnt_sel  input  log2(N_CH)  selects the counter shown on match_cnt.
REQ-013 match_cnt  output  CNT_W  combinational readout of counter[cnt_sel].

Function
REQ-014 The block SHALL hold a 2-bit Moore context per channel: IDLE, GOT1, GOT10, MATCH.
REQ-015 Context transitions on a consumed bit b SHALL be: IDLE b=1->GOT1, b=0->IDLE; GOT1 b=0->GOT10, b=1->GOT1; GOT10 b=1->MATCH, b=0->IDLE; MATCH b=1->GOT1, b=0->GOT10 (overlapping detection).
REQ-016 A channel's context SHALL change only on a cycle where that channel's bit is consumed or cleared.
REQ-017 Eligible channels per cycle SHALL be ch_valid[i] & ~ch_clr[i] & en.
REQ-018 Arbitration SHALL be round-robin: grant the first eligible channel at index >= rr_ptr, wrapping modulo N_CH; at most one grant per cycle.
REQ-019 ch_ready SHALL be combinational from eligibility and rr_ptr; ch_ready SHALL be all-zero when en=0 or no channel eligible.
REQ-020 After a grant to channel g, rr_ptr SHALL become (g+1) mod N_CH; with no grant, rr_ptr SHALL hold.
REQ-021 When the granted channel's next context is MATCH, match_valid SHALL be 1 and match_ch SHALL equal g in the cycle after the consuming edge (latency 1); otherwise match_valid SHALL be 0 and match_ch SHALL hold its last value.
REQ-022 On each match, counter[g] SHALL increment by 1, saturating at 2^CNT_W-1 (no wrap); match_valid still pulses when saturated.
REQ-023 ch_clr[i] SHALL set context[i] to IDLE and counter[i] to 0 at the next edge; a clear and a pending bit on the same channel SHALL never both take effect (channel excluded from grant).
REQ-024 Clears on multiple channels in one cycle SHALL all take effect; a clear on channel i SHALL not disturb a grant to channel j != i.
REQ-025 Deasserting en mid-stream SHALL freeze all contexts, counters and rr_ptr; reassertion resumes with no loss of context.
REQ-026 match_cnt SHALL reflect counter[cnt_sel] updated values in the cycle after the updating edge.

Reset
REQ-027 While rst=1 at a clock edge: all contexts IDLE, all counters 0, rr_ptr 0, match_valid 0, match_ch 0.
REQ-028 rst SHALL override ch_clr, en and any simultaneous grant; ch_ready SHALL be all-zero in cycles where rst=1.
REQ-029 A partial sequence interrupted by reset SHALL not produce a match (e.g. "10", rst, "1" -> no match).

Verification
REQ-030 Single channel 0, en=1, bits 1,0,1,0,1 on consecutive cycles -> match_valid pulses after 3rd and 5th bits, match_ch=0, counter[0]=2.
REQ-031 All 4 channels valid continuously, rr_ptr=0 -> grants 0,1,2,3,0,... one per cycle; channel i sees a bit every 4th cycle; each channel fed 1,0,1 -> 4 matches, match_ch sequence 0,1,2,3.
REQ-032 Channel 2 fed 1,0 then ch_clr[2] with ch_valid[2]=1 -> no grant to 2 that cycle, context[2]=IDLE; next bit 1 -> no match.
REQ-033 CNT_W=2, channel 1 fed 1,0,1,0,1,0,1,0,1 (4 matches) -> counter[1] saturates at 3, match_valid pulses all 4 times.
REQ-034 Channel 3 fed 1,0, en=0 for 5 cycles with ch_valid[3]=1 -> ch_ready=0, no state change; en=1, bit 1 -> match_valid=1, match_ch=3.
REQ-035 rst asserted mid-traffic on all channels -> next cycle match_valid=0, counters 0, rr_ptr 0, first post-reset grant goes to lowest-index valid channel.
